bound_flasher_fsm: RTL and testbench

Lamp sequencer that consumes the one-cycle step pulse produced by the clock divider. It drives a 16-lamp bar through the bound-flasher sequence: staged fill/drain phases, kickback on `flag`, and a final blink burst. All state advances only on step pulses. `clk` runs at system rate.

---
 rtl/bound_flasher_fsm.sv | 124 ++++++++++++
 tb/tb_bound_flasher_fsm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bound_flasher_fsm.sv
// Bound-flasher lamp sequencer: staged fill/drain of a 16-lamp bar with kickback
// on flag and a closing blink burst; every transition is gated by the step pulse.
module bound_flasher_fsm #(
    parameter int BLINK_PAIRS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        flag,
    output logic [15:0] lamp,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_UP1   = 4'd1,
        S_DN1   = 4'd2,
        S_UP2   = 4'd3,
        S_DN2   = 4'd4,
        S_UP3   = 4'd5,
        S_DN3   = 4'd6,
        S_BLINK = 4'd7
    } state_t;

    localparam logic [3:0] LAST_B = 4'(2 * BLINK_PAIRS);

    state_t      state_q, state_d;
    logic [4:0]  n_q, n_d;
    logic [3:0]  b_q, b_d;
    logic [15:0] lamp_q, lamp_d;
    logic        busy_q, busy_d;
    logic [3:0]  b_inc;
    logic [16:0] therm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= 5'd0;
            b_q     <= 4'd0;
            lamp_q  <= 16'h0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            b_q     <= b_d;
            lamp_q  <= lamp_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        b_d     = b_q;
        b_inc   = b_q + 4'd1;
        case (state_q)
            S_IDLE: if (tick && flag) begin
                n_d     = 5'd1;
                state_d = S_UP1;
            end
            S_UP1: if (tick) begin
                n_d = n_q + 5'd1;
                if (n_d == 5'd6) state_d = S_DN1;
            end
            S_DN1: if (tick) begin
                n_d = n_q - 5'd1;
                if (n_d == 5'd0) state_d = S_UP2;
            end
            S_UP2: if (tick) begin
                // Kickback wins over the normal increment
                if (flag && n_q == 5'd6) begin
                    n_d     = 5'd5;
                    state_d = S_DN1;
                end else begin
                    n_d = n_q + 5'd1;
                    if (n_d == 5'd11) state_d = S_DN2;
                end
            end
            S_DN2: if (tick) begin
                n_d = n_q - 5'd1;
                if (n_d == 5'd5) state_d = S_UP3;
            end
            S_UP3: if (tick) begin
                if (flag && n_q == 5'd11) begin
                    n_d     = 5'd10;
                    state_d = S_DN2;
                end else begin
                    n_d = n_q + 5'd1;
                    if (n_d == 5'd16) state_d = S_DN3;
                end
            end
            S_DN3: if (tick) begin
                n_d = n_q - 5'd1;
                if (n_d == 5'd0) begin
                    b_d     = 4'd0;
                    state_d = S_BLINK;
                end
            end
            S_BLINK: if (tick) begin
                if (b_inc == LAST_B) begin
                    b_d     = 4'd0;
                    n_d     = 5'd0;
                    state_d = S_IDLE;
                end else begin
                    b_d = b_inc;
                end
            end
            default: begin
                // Illegal encodings recover without waiting for a step
                state_d = S_IDLE;
                n_d     = 5'd0;
                b_d     = 4'd0;
            end
        endcase

        therm  = (17'd1 << n_d) - 17'd1;
        lamp_d = (state_d == S_BLINK) ? {16{b_d[0]}} : therm[15:0];
        busy_d = (state_d != S_IDLE);
    end

    assign lamp = lamp_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_bound_flasher_fsm.sv
// Bench for bound_flasher_fsm: vector table, spec-derived golden run, kickback,
// reset and tick-hold corner cases, then random stimulus against a phase-list model.
module tb_bound_flasher_fsm;

    localparam int BP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        flag;
    logic [15:0] lamp;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];

    // model: phase 0 idle, 1..6 ramps, 7 blink
    int m_ph, m_n, m_b;
    int tgt[7] = '{0, 6, 0, 11, 5, 16, 0};

    typedef struct {
        logic        tick;
        logic        flag;
        logic [15:0] lamp;
        logic        busy;
    } vec_t;

    vec_t vecs[10];

    bound_flasher_fsm #(.BLINK_PAIRS(BP)) dut (
        .clk (clk),
        .rst (rst),
        .tick(tick),
        .flag(flag),
        .lamp(lamp),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] therm(input int k);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < k; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [15:0] model_lamp();
        if (m_ph == 7) return (m_b % 2 == 1) ? 16'hFFFF : 16'h0000;
        return therm(m_n);
    endfunction

    task automatic model_reset();
        m_ph = 0;
        m_n  = 0;
        m_b  = 0;
    endtask

    task automatic model_step(input logic t, input logic f);
        bit up;
        if (!t) return;
        if (m_ph == 0) begin
            if (f) begin
                m_n  = 1;
                m_ph = 1;
            end
        end else if (m_ph == 7) begin
            m_b++;
            if (m_b == 2 * BP) begin
                m_ph = 0;
                m_b  = 0;
                m_n  = 0;
            end
        end else begin
            up = (m_ph % 2 == 1);
            // an up ramp bounces back when flag meets the previous up ramp's peak
            if (up && m_ph > 1 && f && m_n == tgt[m_ph - 2]) begin
                m_n  = m_n - 1;
                m_ph = m_ph - 1;
            end else begin
                m_n = up ? m_n + 1 : m_n - 1;
                if (m_n == tgt[m_ph]) begin
                    m_ph++;
                    if (m_ph == 7) m_b = 0;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, got, expv);
        end
    endtask

    task automatic drive(input logic t, input logic f);
        tick = t;
        flag = f;
        @(posedge clk);
        #1;
        tick = 1'b0;
        flag = 1'b0;
        model_step(t, f);
    endtask

    task automatic step_cmp(input logic t, input logic f, input string nm);
        drive(t, f);
        chk({nm, " lamp"}, lamp, model_lamp());
        chk({nm, " busy"}, {15'b0, busy}, {15'b0, m_ph != 0});
    endtask

    task automatic do_reset(input string nm);
        #2 rst = 1'b1;
        #1;
        chk({nm, " rst lamp"}, lamp, 16'h0000);
        chk({nm, " rst busy"}, {15'b0, busy}, 16'h0000);
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic ramp(input int a, input int b);
        int k;
        k = a;
        while (k != b) begin
            k = (b > a) ? k + 1 : k - 1;
            exp_q.push_back(therm(k));
        end
    endtask

    task automatic build_exp();
        exp_q.delete();
        ramp(0, 6);
        ramp(6, 0);
        ramp(0, 11);
        ramp(11, 5);
        ramp(5, 16);
        ramp(16, 0);
        repeat (BP) begin
            exp_q.push_back(16'hFFFF);
            exp_q.push_back(16'h0000);
        end
    endtask

    // full no-kickback run compared against the spec-derived golden sequence
    task automatic golden_run(input bit flag_outside, input string nm);
        logic [15:0] e;
        logic        f;
        build_exp();
        for (int s = 1; s <= 62; s++) begin
            f = (s == 1) ? 1'b1 : 1'b0;
            if (flag_outside && !((m_ph == 3 && m_n == 6) || (m_ph == 5 && m_n == 11))) f = 1'b1;
            drive(1'b1, f);
            e = exp_q.pop_front();
            chk($sformatf("%s step%0d lamp", nm, s), lamp, e);
            chk($sformatf("%s step%0d busy", nm, s), {15'b0, busy}, {15'b0, s < 62});
        end
    endtask

    // run with one kickback at the given phase/level; returns steps until busy falls
    task automatic kick_run(input int ph, input int lvl, input logic [15:0] after,
                            input string nm, output int steps);
        bit done;
        bit kick;
        done  = 0;
        steps = 0;
        step_cmp(1'b1, 1'b1, nm);
        steps = 1;
        while (busy && steps < 300) begin
            kick = !done && m_ph == ph && m_n == lvl;
            step_cmp(1'b1, kick, nm);
            steps++;
            if (kick) begin
                done = 1;
                chk({nm, " after kick"}, lamp, after);
            end
        end
    endtask

    initial begin
        int          steps;
        int          changes;
        logic [15:0] held;

        rst  = 1'b1;
        tick = 1'b0;
        flag = 1'b0;
        model_reset();
        #1;
        chk("reset lamp", lamp, 16'h0000);
        chk("reset busy", {15'b0, busy}, 16'h0000);
        #20 rst = 1'b0;

        vecs[0] = '{1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h0001, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 16'h0001, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 16'h0003, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'h0007, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 16'h000F, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 16'h001F, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 16'h003F, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 16'h001F, 1'b1};
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].tick, vecs[i].flag);
            chk($sformatf("vec%0d lamp", i), lamp, vecs[i].lamp);
            chk($sformatf("vec%0d busy", i), {15'b0, busy}, {15'b0, vecs[i].busy});
        end
        do_reset("vec");

        golden_run(1'b0, "gold");
        golden_run(1'b1, "flaghold");
        // flag was high on the final blink step: still idle afterwards
        step_cmp(1'b1, 1'b0, "post-blink idle");

        kick_run(3, 6, 16'h001F, "kick2", steps);
        chk("kick2 steps", 16'(steps), 16'd74);
        kick_run(5, 11, 16'h03FF, "kick3", steps);
        chk("kick3 steps", 16'(steps), 16'd74);

        step_cmp(1'b1, 1'b1, "midup3");
        for (int i = 0; i < 200 && !(m_ph == 5 && m_n == 9); i++) step_cmp(1'b1, 1'b0, "midup3");
        chk("midup3 reached", lamp, 16'h01FF);
        do_reset("midup3");
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0);
            chk("post-reset idle lamp", lamp, 16'h0000);
        end

        tick = 1'b1;
        flag = 1'b1;
        repeat (6) begin
            @(posedge clk);
            model_step(1'b1, 1'b1);
        end
        #1;
        tick = 1'b0;
        flag = 1'b0;
        chk("tickhold lamp", lamp, 16'h003F);
        held    = lamp;
        changes = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (lamp !== held) changes++;
        end
        chk("stable 100", 16'(changes), 16'd0);
        step_cmp(1'b1, 1'b0, "tickhold dn1");
        chk("tickhold dn1 value", lamp, 16'h001F);
        do_reset("tickhold");

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset("rand");
            step_cmp($urandom_range(0, 9) < 4, $urandom_range(0, 4) == 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
